// File: rtl/iir_sos_cascade_tdm.sv
// Cascade of second-order IIR sections that share one multiplier-accumulator.
// Coefficients live in a host-writable register file; one sample per trigger.
module iir_sos_cascade_tdm #(
    parameter int COEF_SIZE  = 20,
    parameter int COEF_FRAC  = 18,
    parameter int DATA_SIZE  = 24,
    parameter int NUM_STAGES = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DATA_SIZE-1:0] data_in_i,
    input  logic                 sample_trig_i,
    output logic [DATA_SIZE-1:0] data_out_o,
    output logic                 filter_done_o,
    output logic                 busy_o,
    output logic                 overrun_o,
    input  logic                 coef_we_i,
    input  logic [7:0]           coef_addr_i,
    input  logic [COEF_SIZE-1:0] coef_wdata_i,
    input  logic                 clear_state_i
);

    localparam int PROD_W   = DATA_SIZE + COEF_SIZE;
    localparam int ACC_W    = PROD_W + 3;
    localparam int NUM_COEF = 6 * NUM_STAGES;
    localparam int STG_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CI_W     = $clog2(NUM_COEF);
    localparam int HALF     = 1 << (COEF_FRAC - 1);
    localparam logic [STG_W-1:0]     LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [COEF_SIZE-1:0] UNITY    = COEF_SIZE'(32'd1 << COEF_FRAC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAIN  = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [2:0]       phase_q, phase_d;

    logic signed [DATA_SIZE-1:0] x_q, w_q, data_out_q;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic                        filter_done_q, busy_q, overrun_q;

    logic signed [COEF_SIZE-1:0] coef_q [NUM_COEF];
    logic signed [DATA_SIZE-1:0] w1_q [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] w2_q [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] y1_q [NUM_STAGES];
    logic signed [DATA_SIZE-1:0] y2_q [NUM_STAGES];

    logic [2:0]                  sel_s;
    logic [CI_W-1:0]             coef_idx_s;
    logic signed [DATA_SIZE-1:0] mul_a_s;
    logic signed [COEF_SIZE-1:0] mul_b_s;
    logic signed [PROD_W-1:0]    prod_s;
    logic signed [ACC_W-1:0]     prod_ext_s;
    logic signed [DATA_SIZE-1:0] w_new_s, y_s;
    logic                        last_stage_s;

    // Round half up by COEF_FRAC bits, then clamp to the sample range.
    function automatic logic signed [DATA_SIZE-1:0] rnd_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = v + ACC_W'(HALF);
        r = r >>> COEF_FRAC;
        if (r[ACC_W-1:DATA_SIZE-1] == {(ACC_W-DATA_SIZE+1){r[ACC_W-1]}}) begin
            rnd_sat = r[DATA_SIZE-1:0];
        end else if (r[ACC_W-1]) begin
            rnd_sat = {1'b1, {(DATA_SIZE-1){1'b0}}};
        end else begin
            rnd_sat = {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
    endfunction

    // Operand select: GAIN uses coefficient 0, MAC phases walk B0,B1,B2,A1,A2.
    always_comb begin
        sel_s   = 3'd0;
        mul_a_s = '0;
        case (state_q)
            S_GAIN: begin
                sel_s   = 3'd0;
                mul_a_s = x_q;
            end
            S_MAC: begin
                case (phase_q)
                    3'd0: begin sel_s = 3'd1; mul_a_s = w_q;           end
                    3'd1: begin sel_s = 3'd2; mul_a_s = w1_q[stage_q]; end
                    3'd2: begin sel_s = 3'd3; mul_a_s = w2_q[stage_q]; end
                    3'd3: begin sel_s = 3'd4; mul_a_s = y1_q[stage_q]; end
                    3'd4: begin sel_s = 3'd5; mul_a_s = y2_q[stage_q]; end
                    default: begin sel_s = 3'd0; mul_a_s = '0; end
                endcase
            end
            default: begin
                sel_s   = 3'd0;
                mul_a_s = '0;
            end
        endcase
    end

    assign coef_idx_s   = CI_W'(int'(stage_q) * 6 + int'(sel_s));
    assign mul_b_s      = coef_q[coef_idx_s];
    assign prod_s       = $signed({{COEF_SIZE{mul_a_s[DATA_SIZE-1]}}, mul_a_s})
                        * $signed({{DATA_SIZE{mul_b_s[COEF_SIZE-1]}}, mul_b_s});
    assign prod_ext_s   = $signed({{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s});
    assign w_new_s      = rnd_sat(prod_ext_s);
    assign y_s          = rnd_sat(acc_q);
    assign last_stage_s = (stage_q == LAST_STG);

    // Accumulator next value; feedback terms (A1, A2) are subtracted.
    always_comb begin
        acc_d = acc_q;
        if (state_q == S_MAC) begin
            if (phase_q == 3'd0) begin
                acc_d = prod_ext_s;
            end else if (phase_q >= 3'd3) begin
                acc_d = acc_q - prod_ext_s;
            end else begin
                acc_d = acc_q + prod_ext_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Sequencer next state: per stage GAIN, five MAC phases, WRITE.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (sample_trig_i) begin
                    state_d = S_GAIN;
                    stage_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAIN: begin
                state_d = S_MAC;
                phase_d = 3'd0;
            end
            S_MAC: begin
                if (phase_q == 3'd4) begin
                    state_d = S_WRITE;
                    phase_d = 3'd0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            S_WRITE: begin
                if (last_stage_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_GAIN;
                    stage_d = stage_q + STG_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, working sample, accumulator and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            stage_q       <= '0;
            phase_q       <= 3'd0;
            x_q           <= '0;
            w_q           <= '0;
            acc_q         <= '0;
            data_out_q    <= '0;
            filter_done_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            phase_q       <= phase_d;
            acc_q         <= acc_d;
            busy_q        <= (state_d != S_IDLE);
            filter_done_q <= (state_q == S_WRITE) && last_stage_s;
            if (sample_trig_i && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            if ((state_q == S_IDLE) && sample_trig_i) begin
                x_q <= data_in_i;
            end else if (state_q == S_WRITE) begin
                x_q <= y_s;
            end
            if (state_q == S_GAIN) begin
                w_q <= w_new_s;
            end
            if ((state_q == S_WRITE) && last_stage_s) begin
                data_out_q <= y_s;
            end
        end
    end

    // Delay lines and coefficient file; host access is only honoured while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
            for (int j = 0; j < NUM_COEF; j++) begin
                coef_q[j] <= ((j % 6) < 2) ? UNITY : '0;
            end
        end else if (state_q == S_IDLE) begin
            if (clear_state_i) begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    w1_q[i] <= '0;
                    w2_q[i] <= '0;
                    y1_q[i] <= '0;
                    y2_q[i] <= '0;
                end
            end
            if (coef_we_i && (coef_addr_i < 8'(NUM_COEF))) begin
                coef_q[coef_addr_i[CI_W-1:0]] <= coef_wdata_i;
            end
        end else if (state_q == S_WRITE) begin
            w1_q[stage_q] <= w_q;
            w2_q[stage_q] <= w1_q[stage_q];
            y1_q[stage_q] <= y_s;
            y2_q[stage_q] <= y1_q[stage_q];
        end
    end

    assign data_out_o    = data_out_q;
    assign filter_done_o = filter_done_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_iir_sos_cascade_tdm.sv
// Randomised and directed checks of the SOS cascade against a plain-arithmetic
// model of the filter equations.
module tb_iir_sos_cascade_tdm;

    localparam int NS  = 4;
    localparam int NC  = 6 * NS;
    localparam int LAT = 7 * NS + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] data_in;
    logic        sample_trig;
    logic [23:0] data_out;
    logic        filter_done;
    logic        busy;
    logic        overrun;
    logic        coef_we;
    logic [7:0]  coef_addr;
    logic [19:0] coef_wdata;
    logic        clear_state;

    int checks = 0;
    int errors = 0;

    longint mc  [NC];
    longint mw1 [NS];
    longint mw2 [NS];
    longint my1 [NS];
    longint my2 [NS];

    always #5 clk = ~clk;

    iir_sos_cascade_tdm #(
        .COEF_SIZE (20),
        .COEF_FRAC (18),
        .DATA_SIZE (24),
        .NUM_STAGES(NS)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .data_in_i     (data_in),
        .sample_trig_i (sample_trig),
        .data_out_o    (data_out),
        .filter_done_o (filter_done),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .coef_we_i     (coef_we),
        .coef_addr_i   (coef_addr),
        .coef_wdata_i  (coef_wdata),
        .clear_state_i (clear_state)
    );

    function automatic longint rs(input longint v);
        longint r;
        r = (v + 64'sd131072) >>> 18;
        if (r > 64'sd8388607) r = 64'sd8388607;
        else if (r < -64'sd8388608) r = -64'sd8388608;
        return r;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            mw1[s] = 0; mw2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) mc[i] = ((i % 6) < 2) ? 64'sd262144 : 64'sd0;
        model_clear();
    endtask

    task automatic model_step(input longint x, output longint y);
        longint v, w, yy;
        v = x;
        for (int s = 0; s < NS; s++) begin
            w  = rs(mc[6*s] * v);
            yy = rs(mc[6*s+1] * w + mc[6*s+2] * mw1[s] + mc[6*s+3] * mw2[s]
                    - mc[6*s+4] * my1[s] - mc[6*s+5] * my2[s]);
            mw2[s] = mw1[s]; mw1[s] = w;
            my2[s] = my1[s]; my1[s] = yy;
            v = yy;
        end
        y = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int addr, input longint val);
        logic signed [19:0] v20;
        v20 = 20'(val);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 8'(addr); coef_wdata = v20;
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < NC) mc[addr] = longint'(v20);
    endtask

    task automatic send_sample(input longint x, input bit clr, output longint got);
        longint exp;
        int k;
        bit seen;
        if (clr) model_clear();
        model_step(x, exp);
        @(negedge clk);
        data_in = 24'(x); clear_state = clr; sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0; clear_state = 1'b0;
        k = 1; seen = 1'b0;
        while (!seen && k <= 100) begin
            if (filter_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_during T+%0d: got %b want 1", k, busy);
                end
                @(negedge clk);
                k++;
            end
        end
        got = longint'($signed(data_out));
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no filter_done within 100 cycles");
        end
        checks++;
        if (k != LAT) begin
            errors++;
            $display("FAIL latency: got T+%0d want T+%0d", k, LAT);
        end
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL data_out x=%0d: got %0d want %0d", x, got, exp);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_done: got %b want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || filter_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after: busy=%b done=%b want 0 0", busy, filter_done);
        end
        checks++;
        if (longint'($signed(data_out)) != exp) begin
            errors++;
            $display("FAIL data_out_hold: got %0d want %0d", $signed(data_out), exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (data_out !== 24'd0 || filter_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dout=%0d done=%b busy=%b ovr=%b want 0 0 0 0",
                     data_out, filter_done, busy, overrun);
        end
    endtask

    task automatic test_passthrough();
        longint got;
        send_sample(64'sd1000, 1'b0, got);
        checks++;
        if (got != 64'sd1000) begin
            errors++;
            $display("FAIL passthrough: got %0d want 1000", got);
        end
    endtask

    task automatic test_pure_delay();
        longint got;
        longint ins [3] = '{64'sd100, 64'sd0, 64'sd0};
        longint outs[3] = '{64'sd0, 64'sd100, 64'sd0};
        do_reset();
        write_coef(1, 0);
        write_coef(2, 262144);
        for (int i = 0; i < 3; i++) begin
            send_sample(ins[i], 1'b0, got);
            checks++;
            if (got != outs[i]) begin
                errors++;
                $display("FAIL pure_delay[%0d]: got %0d want %0d", i, got, outs[i]);
            end
        end
    endtask

    task automatic test_saturation();
        longint got;
        do_reset();
        write_coef(0, 393216);
        send_sample(64'sd8000000, 1'b0, got);
        checks++;
        if (got != 64'sd8388607) begin
            errors++;
            $display("FAIL sat_pos: got %0d want 8388607", got);
        end
        send_sample(-64'sd8000000, 1'b0, got);
        checks++;
        if (got != -64'sd8388608) begin
            errors++;
            $display("FAIL sat_neg: got %0d want -8388608", got);
        end
    endtask

    task automatic test_overrun();
        longint exp, got;
        int dones, done_k;
        do_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_init: got %b want 0", overrun);
        end
        model_step(64'sd2222, exp);
        @(negedge clk);
        data_in = 24'd2222; sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
        dones = 0; done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            if (filter_done === 1'b1) begin
                dones++;
                done_k = k;
                checks++;
                if (longint'($signed(data_out)) != exp) begin
                    errors++;
                    $display("FAIL overrun_data: got %0d want %0d", $signed(data_out), exp);
                end
            end
            sample_trig = (k == 5);
            if (k == 5) data_in = 24'd5555;
            coef_we = (k == 10); coef_addr = 8'd0; coef_wdata = 20'd0;
            @(negedge clk);
        end
        sample_trig = 1'b0; coef_we = 1'b0;
        checks++;
        if (dones != 1 || done_k != LAT) begin
            errors++;
            $display("FAIL overrun_done: got %0d pulses at T+%0d want 1 at T+%0d", dones, done_k, LAT);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b want 1", overrun);
        end
        send_sample(64'sd4321, 1'b0, got);
        checks++;
        if (got != 64'sd4321) begin
            errors++;
            $display("FAIL write_while_busy: got %0d want 4321", got);
        end
    endtask

    task automatic test_recursion();
        longint got;
        longint outs[4] = '{64'sd1024, 64'sd512, 64'sd256, 64'sd128};
        do_reset();
        write_coef(4, -131072);
        for (int i = 0; i < 4; i++) begin
            send_sample((i == 0) ? 64'sd1024 : 64'sd0, 1'b0, got);
            checks++;
            if (got != outs[i]) begin
                errors++;
                $display("FAIL recursion[%0d]: got %0d want %0d", i, got, outs[i]);
            end
        end
        send_sample(64'sd1024, 1'b1, got);
        checks++;
        if (got != 64'sd1024) begin
            errors++;
            $display("FAIL clear_with_trig: got %0d want 1024", got);
        end
    endtask

    task automatic test_random();
        longint got, val;
        int nw;
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) begin
                val = longint'($urandom_range(0, 524288)) - 64'sd262144;
                write_coef($urandom_range(0, 29), val);
            end
            val = longint'($urandom_range(0, 16777215)) - 64'sd8388608;
            send_sample(val, ($urandom_range(0, 7) == 0), got);
        end
    endtask

    task automatic test_reset_mid();
        longint got;
        bit bad_done;
        @(negedge clk);
        data_in = 24'd3333; sample_trig = 1'b1;
        @(negedge clk);
        sample_trig = 1'b0;
        bad_done = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            if (filter_done === 1'b1) bad_done = 1'b1;
            if (k == 13) begin
                checks++;
                if (busy !== 1'b0 || data_out !== 24'd0 || overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_state: busy=%b dout=%0d ovr=%b want 0 0 0",
                             busy, data_out, overrun);
                end
            end
            reset = (k == 12);
            @(negedge clk);
        end
        reset = 1'b0;
        model_reset();
        checks++;
        if (bad_done) begin
            errors++;
            $display("FAIL reset_mid_done: got filter_done pulse want none");
        end
        send_sample(-64'sd7, 1'b0, got);
        checks++;
        if (got != -64'sd7) begin
            errors++;
            $display("FAIL reset_mid_coef: got %0d want -7", got);
        end
    endtask

    initial begin
        reset = 1'b1; data_in = 24'd0; sample_trig = 1'b0;
        coef_we = 1'b0; coef_addr = 8'd0; coef_wdata = 20'd0; clear_state = 1'b0;
        model_reset();
        test_reset();
        test_passthrough();
        test_pure_delay();
        test_saturation();
        test_overrun();
        test_recursion();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_sos_cascade_tdm.md
Name: iir_sos_cascade_tdm

Overview:
- Parametrised cascade of NUM_STAGES second-order IIR sections. All sections share one time-multiplexed multiplier-accumulator.
- Coefficients are held in an internal register file and are writable at run time from a host port, replacing fixed per-instance parameters.
- One sample is processed per sample_trig. Completion is signalled by filter_done, so the block drops into the existing audio filter chain.

Parameters:
- COEF_SIZE, 20, coefficient width; signed two's complement.
- COEF_FRAC, 18, coefficient fractional bits. 1.0 = 2^18 = 262144.
- DATA_SIZE, 24, sample width; signed two's complement.
- NUM_STAGES, 4, number of SOS sections (1..16).

Ports:
- clk, input, 1, sole clock; all logic rising-edge.
- reset, input, 1, synchronous, active-high.
- data_in, input, DATA_SIZE, input sample. Latched on an accepted sample_trig.
- sample_trig, input, 1, single-cycle start pulse.
- data_out, output, DATA_SIZE, filtered sample. Held until the next completion.
- filter_done, output, 1, one-cycle pulse; data_out is valid in that same cycle.
- busy, output, 1, high from the cycle after an accepted trigger through the filter_done cycle.
- overrun, output, 1, sticky. Set when sample_trig arrives while busy=1. Cleared only by reset.
- coef_we, input, 1, coefficient write strobe.
- coef_addr, input, 8, address = stage*6 + idx. idx: 0=GAIN, 1=B0, 2=B1, 3=B2, 4=A1, 5=A2.
- coef_wdata, input, COEF_SIZE, coefficient value.
- clear_state, input, 1, zeroes all delay-line registers. Honoured only when busy=0.

Behaviour:
- Reset values:
  - data_out=0, filter_done=0, busy=0, overrun=0.
  - All delay registers (w1, w2, y1, y2 per stage) = 0.
  - Coefficients per stage: GAIN=B0=2^COEF_FRAC; B1=B2=A1=A2=0. Each stage therefore passes the sample through.
- Per-stage equations (stage input x, stage output y):
  - w = sat(rnd(GAIN*x)).
  - y = sat(rnd(B0*w + B1*w1 + B2*w2 - A1*y1 - A2*y2)).
  - Then update: w2<=w1, w1<=w, y2<=y1, y1<=y.
  - Stage k output feeds stage k+1. The last stage output drives data_out.
- Arithmetic:
  - Products are full width (DATA_SIZE+COEF_SIZE).
  - Accumulator is DATA_SIZE+COEF_SIZE+3 bits; no internal overflow.
  - rnd(v) = (v + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up).
  - sat clamps to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
- FSM states: IDLE, GAIN, MAC (5 cycles, phase counter 0..4), WRITE, DONE.
  - IDLE: when sample_trig=1, latch data_in and go to GAIN with stage=0.
  - GAIN: compute w (1 cycle).
  - MAC: accumulate one product per cycle.
  - WRITE: update this stage's delay registers. If stage<NUM_STAGES-1, increment stage and go to GAIN; otherwise go to DONE.
  - DONE: register data_out, pulse filter_done, return to IDLE.
  - Each stage takes 7 cycles.
- Latency: trigger accepted in cycle T gives filter_done in cycle T+7*NUM_STAGES+1. Maximum trigger rate is one per 7*NUM_STAGES+2 cycles.
- sample_trig while busy=1: ignored, no effect on the datapath, and overrun is set. A trigger in the DONE cycle also counts as busy.
- Coefficient writes:
  - With busy=0: a write takes effect from the next cycle.
  - With busy=1: coef_we is ignored and the coefficient is unchanged.
  - coef_addr >= 6*NUM_STAGES: ignored.
- clear_state and sample_trig in the same IDLE cycle: the clear applies first; the new sample then runs on zeroed state.
- reset mid-operation: FSM returns to IDLE next cycle, all reset values are restored (coefficients included), and no filter_done is produced.

Test Plan:
- After reset, pass-through: trigger with data_in=1000, NUM_STAGES=4 -> filter_done at T+29, data_out=1000; busy high for cycles T+1..T+29.
- Pure delay: write stage0 B0=0, B1=262144; drive inputs 100, 0, 0 -> outputs 0, 100, 0.
- Saturation: write stage0 GAIN=393216 (1.5); data_in=8000000 -> data_out=8388607. With data_in=-8000000 -> data_out=-8388608.
- Overrun and write-while-busy:
  - Second sample_trig at T+5 -> ignored, overrun=1, single filter_done at T+29.
  - coef_we at T+10 writing stage0 GAIN=0 -> ignored; the next sample still passes unchanged.
- Recursion: stage0 A1=-131072 (-0.5); impulse 1024 followed by zeros -> outputs 1024, 512, 256, 128.
- Reset at T+12 -> no filter_done, data_out=0, coefficients back to pass-through. A following trigger with data_in=-7 -> data_out=-7.
